uart_tx_core: RTL and testbench

Parametrised, buffered UART transmitter for the LED-matrix echo/telemetry path. Accepts words over a valid/ready handshake into an internal FIFO and serialises them with configurable data width, parity and stop bits. Frames are sent back-to-back with no idle gap while the FIFO holds data. Replaces the single-word transmitter wherever more than one byte is queued or a non-8N1 frame is required.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_core.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_core.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types shared by the UART transmit and receive cores.
// Rev 1.0
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  // The reserved encoding 2'b11 falls back to no parity.
  function automatic parity_t decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with a registered head word (no fall-through).
// Rev 1.0
`default_nettype none

module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    next_rd;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign next_rd = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= next_rd;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head register tracks the oldest entry; an incoming word only lands
      // here when it becomes the oldest one.
      if (do_pop && (count > (AW+1)'(1)))
        dout <= mem[next_rd];
      else if (do_push && ((count == '0) || (do_pop && (count == (AW+1)'(1)))))
        dout <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_core.sv
// uart_tx_core: buffered UART transmitter with configurable width, parity and stop bits.
// Rev 1.0
`default_nettype none

module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_two_stop,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BIT_PERIOD);
  localparam int IDX_W      = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_index;
  logic [IDX_W-1:0]     next_index;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] fifo_dout;
  parity_t              par_mode;
  parity_t              cfg_mode;
  logic                 par_bit;
  logic                 next_par_bit;
  logic                 two_stop;
  logic                 stop_second;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 baud_last;
  logic                 stop_last;
  logic                 frame_end;
  logic                 frame_start;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .pop   (frame_start),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tx_ready     = !fifo_full;
  assign baud_last    = (baud_cnt == CNT_LAST);
  assign stop_last    = !two_stop || stop_second;
  assign frame_end    = (state == S_STOP) && baud_last && stop_last;
  // A new frame can start from idle or directly out of the final stop cycle.
  assign frame_start  = !fifo_empty && ((state == S_IDLE) || frame_end);
  assign cfg_mode     = decode_parity(cfg_parity);
  assign next_par_bit = (cfg_mode == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
  assign next_index   = bit_index + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_index   <= '0;
      shift_reg   <= '0;
      par_mode    <= PAR_NONE;
      par_bit     <= 1'b0;
      two_stop    <= 1'b0;
      stop_second <= 1'b0;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      tx_done <= frame_end;
      if (frame_start) begin
        shift_reg   <= fifo_dout;
        par_mode    <= cfg_mode;
        par_bit     <= next_par_bit;
        two_stop    <= cfg_two_stop;
        stop_second <= 1'b0;
        baud_cnt    <= '0;
        state       <= S_START;
        tx          <= 1'b0;
        tx_busy     <= 1'b1;
      end else begin
        if (state != S_IDLE)
          baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
        unique case (state)
          S_IDLE: begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            baud_cnt <= '0;
          end
          S_START: begin
            if (baud_last) begin
              state     <= S_DATA;
              bit_index <= '0;
              tx        <= shift_reg[0];
            end
          end
          S_DATA: begin
            if (baud_last) begin
              if (bit_index == IDX_LAST) begin
                if (par_mode != PAR_NONE) begin
                  state <= S_PARITY;
                  tx    <= par_bit;
                end else begin
                  state       <= S_STOP;
                  tx          <= 1'b1;
                  stop_second <= 1'b0;
                end
              end else begin
                bit_index <= next_index;
                tx        <= shift_reg[next_index];
              end
            end
          end
          S_PARITY: begin
            if (baud_last) begin
              state       <= S_STOP;
              tx          <= 1'b1;
              stop_second <= 1'b0;
            end
          end
          S_STOP: begin
            if (baud_last) begin
              if (!stop_last) begin
                stop_second <= 1'b1;
              end else begin
                state   <= S_IDLE;
                tx_busy <= 1'b0;
              end
            end
          end
          default: begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: checks the serial line of an 8-bit and a 7-bit core against a frame model.
// Rev 1.0
`default_nettype none

module tb_uart_tx_core;

  localparam int BP = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       valid;
  logic [8:0] data;
  logic [1:0] cfg_par;
  logic       cfg_two;

  logic       ready8, tx8, busy8, done8;
  logic [4:0] lvl8;
  logic       ready7, tx7, busy7, done7;
  logic [4:0] lvl7;

  always #5 clk = ~clk;

  uart_tx_core #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .FIFO_DEPTH(16)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid && !sel), .tx_data(data[7:0]),
    .tx_ready(ready8), .cfg_parity(cfg_par), .cfg_two_stop(cfg_two),
    .tx(tx8), .tx_busy(busy8), .tx_done(done8), .fifo_level(lvl8)
  );

  uart_tx_core #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .FIFO_DEPTH(16)
  ) dut7 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid && sel), .tx_data(data[6:0]),
    .tx_ready(ready7), .cfg_parity(cfg_par), .cfg_two_stop(cfg_two),
    .tx(tx7), .tx_busy(busy7), .tx_done(done7), .fifo_level(lvl7)
  );

  logic       mtx, mdone, mbusy, mready;
  logic [4:0] mlevel;
  assign mtx    = sel ? tx7    : tx8;
  assign mdone  = sel ? done7  : done8;
  assign mbusy  = sel ? busy7  : busy8;
  assign mready = sel ? ready7 : ready8;
  assign mlevel = sel ? lvl7   : lvl8;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Config as seen by the core on the most recent edge (the frame-start edge).
  logic [1:0] par_prev = 2'b00;
  logic       two_prev = 1'b0;
  always @(posedge clk) begin
    par_prev <= cfg_par;
    two_prev <= cfg_two;
  end

  int         total = 0;
  int         bad = 0;
  logic [8:0] qd[$];
  int         start_cyc = 0;
  int         done_cyc = 0;
  int         frames_seen = 0;
  int         acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_parity(input logic [8:0] w, input int nb, input logic [1:0] pc);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(w[i]);
    return (pc == 2'b10) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // Line monitor: every frame is checked bit by bit, cycle by cycle.
  initial begin : monitor
    logic [8:0] w;
    int         nb;
    bit         bits[$];
    bit         ok;
    bit         have;
    have = 1'b0;
    forever begin
      if (!have) @(negedge clk);
      have = 1'b0;
      if (rst_n === 1'b1 && mtx === 1'b0) begin
        start_cyc = cyc;
        frames_seen++;
        chk("frame_expected", 32'(qd.size() > 0), 32'd1);
        w  = (qd.size() > 0) ? qd.pop_front() : 9'h000;
        nb = sel ? 7 : 8;
        bits.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(w[i]);
        if (par_prev == 2'b01 || par_prev == 2'b10) bits.push_back(exp_parity(w, nb, par_prev));
        bits.push_back(1'b1);
        if (two_prev) bits.push_back(1'b1);
        ok = 1'b1;
        for (int k = 0; k < bits.size() * BP; k++) begin
          if (k > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            ok = 1'b0;
            break;
          end
          chk("line_bit", 32'(mtx), 32'(bits[k / BP]));
          chk("busy_in_frame", 32'(mbusy), 32'd1);
          if (k > 0) chk("done_mid_frame", 32'(mdone), 32'd0);
        end
        if (ok) begin
          @(negedge clk);
          if (rst_n === 1'b1) begin
            done_cyc = cyc;
            chk("done_pulse", 32'(mdone), 32'd1);
            chk("frame_len", 32'(done_cyc - start_cyc), 32'(bits.size() * BP));
            have = 1'b1;
          end
        end
      end
    end
  end

  task automatic push(input logic [8:0] d);
    logic [8:0] m;
    m     = sel ? 9'h07F : 9'h0FF;
    valid = 1'b1;
    data  = d & m;
    chk("ready_before_push", 32'(mready), 32'd1);
    @(posedge clk);
    qd.push_back(d & m);
    #1 acc_cyc = cyc;
    #1 valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (!(qd.size() == 0 && mbusy === 1'b0 && mlevel == 5'd0) && n < max_cyc) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("idle_timeout", 32'(n < max_cyc), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : stim
    int f0;
    int fill_start;
    int target;
    int a0;
    int n;
    rst_n = 1'b0; sel = 1'b0; valid = 1'b0; data = '0; cfg_par = 2'b00; cfg_two = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx8", 32'(tx8), 32'd1);
    chk("rst_tx7", 32'(tx7), 32'd1);
    chk("rst_ready", 32'(ready8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_level", 32'(lvl8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // 8N1, 0xA5
    push(9'h0A5);
    chk("acc_busy", 32'(busy8), 32'd0);
    chk("acc_level", 32'(lvl8), 32'd1);
    @(posedge clk);
    #2;
    chk("pop_busy", 32'(busy8), 32'd1);
    chk("pop_level", 32'(lvl8), 32'd0);
    chk("tx_fall", 32'(tx8), 32'd0);
    @(posedge clk);
    #2;
    chk("start_latency", 32'(start_cyc - acc_cyc), 32'd1);
    wait_idle(400);
    chk("len_8n1", 32'(done_cyc - start_cyc), 32'd100);

    // Reserved parity code behaves as none, two stop bits
    cfg_par = 2'b11; cfg_two = 1'b1;
    push(9'h03C);
    wait_idle(400);
    chk("len_8n2_p11", 32'(done_cyc - start_cyc), 32'd110);

    // 7E2 on the 7-bit core
    sel = 1'b1; cfg_par = 2'b01; cfg_two = 1'b1;
    push(9'h041);
    wait_idle(400);
    chk("len_7e2", 32'(done_cyc - start_cyc), 32'd110);

    // 7O1, config changed mid-frame must not affect it
    cfg_par = 2'b10; cfg_two = 1'b0;
    push(9'h041);
    repeat (30) begin
      @(posedge clk);
      #2;
    end
    cfg_par = 2'b00; cfg_two = 1'b1;
    wait_idle(400);
    chk("len_7o1_cfgchg", 32'(done_cyc - start_cyc), 32'd100);
    sel = 1'b0; cfg_par = 2'b00; cfg_two = 1'b0;
    @(posedge clk);
    #2;

    // Fill: 17 words back to back
    f0 = frames_seen;
    for (int i = 0; i < 17; i++) push(9'($urandom & 32'hFF));
    chk("fill_ready", 32'(ready8), 32'd0);
    chk("fill_level", 32'(lvl8), 32'd16);
    fill_start = start_cyc;
    wait_idle(17 * 100 + 200);
    chk("fill_frames", 32'(frames_seen - f0), 32'd17);
    chk("fill_gapless", 32'(done_cyc - fill_start), 32'd1700);

    // Simultaneous push and pop at the stop->start edge
    for (int i = 0; i < 4; i++) push(9'($urandom & 32'hFF));
    chk("sim_pre_level", 32'(lvl8), 32'd3);
    target = start_cyc + 100;
    while (cyc < target - 1) begin
      @(posedge clk);
      #2;
    end
    chk("sim_before_level", 32'(lvl8), 32'd3);
    push(9'($urandom & 32'hFF));
    chk("sim_level", 32'(lvl8), 32'd3);
    chk("sim_done_edge", 32'(done8), 32'd1);
    chk("sim_next_start", 32'(tx8), 32'd0);
    wait_idle(700);

    // Randomized bursts with random configs on either core
    for (int r = 0; r < 8; r++) begin
      sel     = 1'($urandom_range(0, 1));
      cfg_par = 2'($urandom_range(0, 3));
      cfg_two = 1'($urandom_range(0, 1));
      n       = int'($urandom_range(1, 4));
      f0      = frames_seen;
      @(posedge clk);
      #2;
      for (int j = 0; j < n; j++) begin
        push(9'($urandom));
        repeat ($urandom_range(0, 40)) begin
          @(posedge clk);
          #2;
        end
      end
      wait_idle(1000);
      chk("rand_frames", 32'(frames_seen - f0), 32'(n));
    end
    sel = 1'b0; cfg_par = 2'b00; cfg_two = 1'b0;
    @(posedge clk);
    #2;

    // Reset during data bit 3 with more words queued
    push(9'h000);
    a0 = acc_cyc;
    push(9'h0FF);
    push(9'h055);
    while (cyc < a0 + 44) begin
      @(posedge clk);
      #2;
    end
    chk("pre_rst_tx", 32'(tx8), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(tx8), 32'd1);
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_level", 32'(lvl8), 32'd0);
    chk("arst_ready", 32'(ready8), 32'd1);
    qd.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    f0 = frames_seen;
    repeat (30) begin
      @(posedge clk);
      #2;
      chk("post_rst_tx", 32'(tx8), 32'd1);
    end
    chk("post_rst_busy", 32'(busy8), 32'd0);
    chk("post_rst_level", 32'(lvl8), 32'd0);
    chk("no_resume", 32'(frames_seen - f0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
